// File: rtl/vga_controller.sv
// VGA timing generator: free-running H/V counters, sync/visible decode, a
// PIXEL_LATENCY-deep alignment line and a registered colour/sync output stage.
module vga_controller #(
    parameter int H_VISIBLE     = 800,
    parameter int H_FRONT       = 40,
    parameter int H_SYNC        = 128,
    parameter int H_BACK        = 88,
    parameter int V_VISIBLE     = 600,
    parameter int V_FRONT       = 1,
    parameter int V_SYNC        = 4,
    parameter int V_BACK        = 23,
    parameter int SYNC_POS      = 1,
    parameter int PIXEL_LATENCY = 1
) (
    input  logic        VGA_CLOCK,
    input  logic        RESET,
    input  logic [2:0]  PIXEL,
    output logic [10:0] PIXEL_H,
    output logic [10:0] PIXEL_V,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        FRAME_START,
    output logic        VISIBLE
);

    localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] V_LAST   = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_LAST  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic        SYNC_INV = (SYNC_POS == 0) ? 1'b1 : 1'b0;

    logic        run_q, run_d;
    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        raw_hs, raw_vs, raw_vis;
    logic [2:0]  dly_in;
    logic [2:0]  dly_tap;
    logic [2:0]  rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;

    // run_q holds (0,0) for one full clock after reset release so that the
    // first FRAME_START pulse is a whole clock wide.
    always_comb begin
        run_d = 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (run_q) begin
            if (h_q == H_LAST) begin
                h_d = 11'd0;
                v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end
    end

    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            run_q <= 1'b0;
            h_q   <= 11'd0;
            v_q   <= 11'd0;
        end else begin
            run_q <= run_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    always_comb begin
        raw_hs  = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
        raw_vs  = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
        raw_vis = (h_q < H_VIS) && (v_q < V_VIS);
        // The post-reset hold clock is not a real pixel; feed the line blank.
        dly_in  = run_q ? {raw_vis, raw_vs, raw_hs} : 3'b000;
    end

    // Delay line element layout: {visible, vsync, hsync}, all active-high.
    generate
        if (PIXEL_LATENCY == 0) begin : g_no_delay
            assign dly_tap = dly_in;
        end else begin : g_delay
            logic [2:0] dly_q [PIXEL_LATENCY];
            logic [2:0] dly_d [PIXEL_LATENCY];

            always_comb begin
                dly_d[0] = dly_in;
                for (int i = 1; i < PIXEL_LATENCY; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge VGA_CLOCK or posedge RESET) begin
                if (RESET) begin
                    for (int i = 0; i < PIXEL_LATENCY; i++) begin
                        dly_q[i] <= 3'b000;
                    end
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign dly_tap = dly_q[PIXEL_LATENCY-1];
        end
    endgenerate

    always_comb begin
        rgb_d = PIXEL & {3{dly_tap[2]}};
        vs_d  = dly_tap[1] ^ SYNC_INV;
        hs_d  = dly_tap[0] ^ SYNC_INV;
    end

    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            rgb_q <= 3'b000;
            hs_q  <= SYNC_INV;
            vs_q  <= SYNC_INV;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign PIXEL_H     = h_q;
    assign PIXEL_V     = v_q;
    assign VISIBLE     = (h_q < H_VIS) && (v_q < V_VIS);
    assign FRAME_START = run_q && (h_q == 11'd0) && (v_q == 11'd0);
    assign VGA_R       = rgb_q[2];
    assign VGA_G       = rgb_q[1];
    assign VGA_B       = rgb_q[0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;

endmodule

// File: tb/tb_vga_controller.sv
// Directed bench: default-timing instance, a latency-2 instance and a tiny
// active-low instance sharing one clock and reset.
module tb_vga_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Default instance
    logic [2:0]  d_pix = 3'b111;
    logic [10:0] d_h, d_v;
    logic        d_r, d_g, d_b, d_hs, d_vs, d_fs, d_vis;
    vga_controller u_def (
        .VGA_CLOCK(clk), .RESET(rst), .PIXEL(d_pix),
        .PIXEL_H(d_h), .PIXEL_V(d_v), .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
        .VGA_HS(d_hs), .VGA_VS(d_vs), .FRAME_START(d_fs), .VISIBLE(d_vis)
    );

    // Latency-2 instance; renderer answers red for coordinates 799 and 800.
    logic [2:0]  l_pix;
    logic [10:0] l_h, l_v;
    logic        l_r, l_g, l_b, l_hs, l_vs, l_fs, l_vis;
    assign l_pix = (l_h == 11'd801 || l_h == 11'd802) ? 3'b100 : 3'b000;
    vga_controller #(.PIXEL_LATENCY(2)) u_lat (
        .VGA_CLOCK(clk), .RESET(rst), .PIXEL(l_pix),
        .PIXEL_H(l_h), .PIXEL_V(l_v), .VGA_R(l_r), .VGA_G(l_g), .VGA_B(l_b),
        .VGA_HS(l_hs), .VGA_VS(l_vs), .FRAME_START(l_fs), .VISIBLE(l_vis)
    );

    // Small instance: H_TOTAL=15, V_TOTAL=8, frame=120 clocks, active-low, wire delay.
    logic [2:0]  s_pix = 3'b011;
    logic [10:0] s_h, s_v;
    logic        s_r, s_g, s_b, s_hs, s_vs, s_fs, s_vis;
    vga_controller #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POS(0), .PIXEL_LATENCY(0)
    ) u_sm (
        .VGA_CLOCK(clk), .RESET(rst), .PIXEL(s_pix),
        .PIXEL_H(s_h), .PIXEL_V(s_v), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
        .VGA_HS(s_hs), .VGA_VS(s_vs), .FRAME_START(s_fs), .VISIBLE(s_vis)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_first = -1, hs_second = -1, hs_cnt = 0;
        int rgb_first = -1, rgb_last = -1, rgb_cnt = 0;
        int fs_cnt = 0, fs_second = -1;
        int vs_first = -1, vs_cnt = 0, max_h = 0, max_v = 0;
        int wait_cnt;

        // Reset state
        repeat (3) step();
        chk("rst_def_h", d_h, 0);
        chk("rst_def_v", d_v, 0);
        chk("rst_def_vis", d_vis, 1);
        chk("rst_def_fs", d_fs, 0);
        chk("rst_def_rgb", {d_r, d_g, d_b}, 0);
        chk("rst_def_hs", d_hs, 0);
        chk("rst_def_vs", d_vs, 0);
        chk("rst_sm_hs", s_hs, 1);
        chk("rst_sm_vs", s_vs, 1);

        rst = 1'b0;
        step();
        chk("rel_def_fs", d_fs, 1);
        chk("rel_sm_fs", s_fs, 1);

        for (int c = 0; c < 2112; c++) begin
            if (c == 1) begin
                chk("c1_def_h", d_h, 1);
                chk("c1_def_fs", d_fs, 0);
            end
            if (d_hs && hs_first < 0) hs_first = c;
            if (d_hs && c >= 1056 && hs_second < 0) hs_second = c;
            if (d_hs && c < 1056) hs_cnt++;
            if (c < 1056 && {d_r, d_g, d_b} == 3'b111) begin
                rgb_cnt++;
                if (rgb_first < 0) rgb_first = c;
                rgb_last = c;
            end
            if (c == 801) chk("lat_r_801", {l_r, l_g, l_b}, 0);
            if (c == 802) chk("lat_r_802", {l_r, l_g, l_b}, 4);
            if (c == 803) chk("lat_r_803", {l_r, l_g, l_b}, 0);
            if (c == 804) chk("lat_r_804", {l_r, l_g, l_b}, 0);
            if (c < 240 && s_fs) begin
                fs_cnt++;
                if (c > 0 && fs_second < 0) fs_second = c;
            end
            if (c < 120 && !s_vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = c;
            end
            if (int'(s_h) > max_h) max_h = int'(s_h);
            if (int'(s_v) > max_v) max_v = int'(s_v);
            step();
        end

        chk("def_hs_first", hs_first, 842);
        chk("def_hs_period", hs_second - hs_first, 1056);
        chk("def_hs_width", hs_cnt, 128);
        chk("def_rgb_cnt", rgb_cnt, 800);
        chk("def_rgb_first", rgb_first, 2);
        chk("def_rgb_last", rgb_last, 801);
        chk("sm_fs_cnt", fs_cnt, 2);
        chk("sm_fs_period", fs_second, 120);
        chk("sm_vs_first", vs_first, 76);
        chk("sm_vs_width", vs_cnt, 30);
        chk("sm_max_h", max_h, 14);
        chk("sm_max_v", max_v, 7);

        // Mid-frame reset while the small instance is inside both sync pulses.
        wait_cnt = 0;
        while (!(s_h == 11'd11 && s_v == 11'd5) && wait_cnt < 200) begin
            step();
            wait_cnt++;
        end
        chk("sm_reach_sync", wait_cnt < 200, 1);
        chk("sm_hs_active", s_hs, 0);
        chk("sm_vs_active", s_vs, 0);
        #3 rst = 1'b1;
        #1;
        chk("mid_sm_hs", s_hs, 1);
        chk("mid_sm_vs", s_vs, 1);
        chk("mid_sm_h", s_h, 0);
        chk("mid_sm_v", s_v, 0);
        chk("mid_sm_rgb", {s_r, s_g, s_b}, 0);
        chk("mid_def_rgb", {d_r, d_g, d_b}, 0);
        step();
        chk("mid_hold_hs", s_hs, 1);
        chk("mid_hold_fs", s_fs, 0);
        rst = 1'b0;
        step();
        chk("mid_rel_fs", s_fs, 1);
        chk("mid_rel_h", s_h, 0);
        chk("mid_rel_v", s_v, 0);
        chk("mid_rel_hs", s_hs, 1);
        step();
        chk("mid_run_h", s_h, 1);
        chk("mid_run_fs", s_fs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
